xor_puf_sequencer: RTL

XOR_PUF_SEQUENCER -- requirements
Module: xor_puf_sequencer

---
 rtl/xor_puf_pkg.sv | 27 ++
 rtl/xor_puf_run_timer.sv | 42 ++++
 rtl/xor_puf_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/xor_puf_pkg.sv
// -----------------------------------------------------------------------------
// xor_puf_pkg
// Shared definitions for the XOR-PUF batch sequencer:
//   - command codes presented to the XOR controller
//   - sequencer FSM state encoding
//   - watchdog margin added to the controller count value
// -----------------------------------------------------------------------------
package xor_puf_pkg;

  localparam logic [7:0] CODE_IDLE = 8'd0;
  localparam logic [7:0] CODE_RUN  = 8'd2;
  localparam logic [7:0] CODE_CAP  = 8'd4;

  // Slack given to the XOR controller beyond its own count before the
  // watchdog declares the run dead.
  localparam logic [16:0] TIMEOUT_MARGIN = 17'd16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_CAP,
    S_ACC,
    S_FIN
  } state_t;

endpackage

// File: rtl/xor_puf_run_timer.sv
// -----------------------------------------------------------------------------
// xor_puf_run_timer
// Watchdog for the RUN phase. Counts consecutive cycles spent in RUN and
// flags expiry during the cycle that completes cnt_val + TIMEOUT_MARGIN of
// them. The count clears whenever RUN is left.
//
// Ports:
//   clk      in   clock
//   reset    in   asynchronous active-low reset
//   running  in   sequencer is in RUN this cycle
//   cnt_val  in   latched XOR-PUF count value
//   expire   out  this RUN cycle reaches the limit
// -----------------------------------------------------------------------------
module xor_puf_run_timer
  import xor_puf_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        running,
  input  logic [15:0] cnt_val,
  output logic        expire
);

  logic [16:0] count;  // RUN cycles already completed
  logic [16:0] limit;

  assign limit  = {1'b0, cnt_val} + TIMEOUT_MARGIN;
  assign expire = running && ((count + 17'd1) == limit);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!running) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 17'd1;
    end
  end

endmodule

// File: rtl/xor_puf_sequencer.sv
// -----------------------------------------------------------------------------
// xor_puf_sequencer
// Runs a batch of XOR-PUF evaluations through an external XOR controller.
// Each run: ARM (code 0) -> RUN (code 2 until xor_done) -> CAP (code 4) ->
// ACC (sample response). The first response becomes the reference in resp;
// later responses OR their disagreement with it into unstable_mask.
//
// Optional feature: define XOR_PUF_SEQ_TIMEOUT_EN to add a RUN watchdog that
// aborts the batch with err=1 after cnt_val+16 RUN cycles without xor_done.
// Without it err is constant 0 and RUN waits indefinitely.
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous active-low reset
//   start          in   batch request, sampled in IDLE only
//   abort          in   cancel batch, returns to IDLE on next edge
//   num_runs       in   evaluations per batch, latched on start
//   cnt_val_in     in   XOR-PUF count value, latched on start
//   code           out  command to XOR controller (0 idle, 2 run, 4 capture)
//   cnt_val        out  latched count value
//   xor_done       in   XOR controller done
//   puf_out_reg    in   XOR controller registered response
//   resp           out  reference (first-run) response
//   unstable_mask  out  bits that differed from resp in any later run
//   run_idx        out  completed runs (saturating)
//   busy           out  batch active
//   valid          out  batch result ready
//   err            out  watchdog timeout (sticky until next accepted start)
// -----------------------------------------------------------------------------
module xor_puf_sequencer
  import xor_puf_pkg::*;
#(
  parameter int RESP_W = 128,
  parameter int RUNS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [RUNS_W-1:0] num_runs,
  input  logic [15:0]       cnt_val_in,
  output logic [7:0]        code,
  output logic [15:0]       cnt_val,
  input  logic              xor_done,
  input  logic [RESP_W-1:0] puf_out_reg,
  output logic [RESP_W-1:0] resp,
  output logic [RESP_W-1:0] unstable_mask,
  output logic [RUNS_W-1:0] run_idx,
  output logic              busy,
  output logic              valid,
  output logic              err
);

  state_t            state, state_next;
  logic [RUNS_W-1:0] num_runs_q;
  logic [RUNS_W-1:0] run_idx_inc;
  logic              start_ok;
  logic              last_run;
  logic              in_run;
  logic              run_timeout;

  // Abort in IDLE also swallows a coincident start.
  assign start_ok    = (state == S_IDLE) && start && !abort && (num_runs != '0);
  assign run_idx_inc = (run_idx == '1) ? run_idx : run_idx + RUNS_W'(1);
  assign last_run    = (run_idx_inc == num_runs_q);
  assign in_run      = (state == S_RUN);
  assign busy        = (state != S_IDLE);

`ifdef XOR_PUF_SEQ_TIMEOUT_EN
  xor_puf_run_timer u_run_timer (
    .clk     (clk),
    .reset   (reset),
    .running (in_run),
    .cnt_val (cnt_val),
    .expire  (run_timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (start_ok) begin
      err <= 1'b0;
    end else if (in_run && !abort && !xor_done && run_timeout) begin
      err <= 1'b1;
    end
  end
`else
  assign run_timeout = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_next = state;
    code       = CODE_IDLE;
    unique case (state)
      S_IDLE: if (start_ok) state_next = S_ARM;
      S_ARM:  state_next = S_RUN;
      S_RUN: begin
        code = CODE_RUN;
        if (xor_done)         state_next = S_CAP;
        else if (run_timeout) state_next = S_IDLE;
      end
      S_CAP: begin
        code       = CODE_CAP;
        state_next = S_ACC;
      end
      S_ACC:  state_next = last_run ? S_FIN : S_ARM;
      S_FIN:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_val       <= '0;
      num_runs_q    <= '0;
      resp          <= '0;
      unstable_mask <= '0;
      run_idx       <= '0;
      valid         <= 1'b0;
    end else if (start_ok) begin
      cnt_val    <= cnt_val_in;
      num_runs_q <= num_runs;
      run_idx    <= '0;
      valid      <= 1'b0;
    end else if (abort && (state != S_IDLE)) begin
      valid <= 1'b0;
    end else if (state == S_ACC) begin
      run_idx <= run_idx_inc;
      if (run_idx == '0) begin
        resp          <= puf_out_reg;
        unstable_mask <= '0;
      end else begin
        unstable_mask <= unstable_mask | (resp ^ puf_out_reg);
      end
      // Raised on entry to FIN, held until the next accepted start.
      if (last_run) valid <= 1'b1;
    end
  end

endmodule
